// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART transmitter slice.
//   tx_state_t     - transmitter FSM states (PARITY is only reached when
//                    UART_TX_PARITY_EN is defined)
//   UART_DATA_BITS - payload bits per frame
//   clks_per_bit() - system clocks per line bit (integer divide)
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int unsigned UART_DATA_BITS = 8;

    function automatic int unsigned clks_per_bit(input int unsigned freq, input int unsigned baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_mmio_if.sv
// uart_tx_mmio_if: MMIO store path and FIFO status of the UART transmitter.
//   mmio_wea   - store strobe, one byte pushed per high cycle
//   mmio_dat   - store data, only [7:0] used
//   fifo_full  - FIFO holds FIFO_DEPTH bytes
//   fifo_count - bytes queued, excluding the byte on the line
//   overflow   - one-cycle pulse when a store was dropped
// master: store issuer (core); slave: the transmitter.
interface uart_tx_mmio_if #(
    parameter int unsigned FIFO_DEPTH = 16
);
    logic                          mmio_wea;
    logic [31:0]                   mmio_dat;
    logic                          fifo_full;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          overflow;

    modport master (
        output mmio_wea,
        output mmio_dat,
        input  fifo_full,
        input  fifo_count,
        input  overflow
    );

    modport slave (
        input  mmio_wea,
        input  mmio_dat,
        output fifo_full,
        output fifo_count,
        output overflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous byte FIFO feeding the transmitter.
//   clk, Rst - clock, synchronous active-high reset (pointers and count cleared)
//   push/din - write din when not full (full evaluated on pre-edge state)
//   pop/dout - dout is combinational from the read pointer; pop advances it
//   full, empty, count - derived from the occupancy counter
// Pointers are $clog2(DEPTH) bits and wrap naturally; DEPTH must be a power of 2.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     Rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [CW-1:0] count_q;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem[rptr_q];
    // A same-cycle pop never frees a slot for the push: both use pre-edge state.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (pop_ok) begin
                rptr_q <= rptr_q + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                count_q <= count_q + CW'(1);
            end else if (!push_ok && pop_ok) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: MMIO-fed UART transmitter, 8N1 LSB first.
//   clk  - system clock
//   Rst  - synchronous active-high reset; aborts any frame, discards the FIFO
//   bus  - uart_tx_mmio_if.slave: mmio_wea/mmio_dat in, fifo_full/fifo_count/overflow out
//   tx   - serial line, idle high, driven from a flop
//   busy - frame in progress or FIFO not empty
// Optional: define UART_TX_PARITY_EN to insert an even-parity bit between DATA and STOP.
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned BAUD        = 9600,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic               clk,
    input  logic               Rst,
    uart_tx_mmio_if.slave      bus,
    output logic               tx,
    output logic               busy
);
    localparam int unsigned CPB = clks_per_bit(CLK_FREQ_HZ, BAUD);
    localparam int unsigned BW  = (CPB > 2) ? $clog2(CPB) : 1;
    localparam logic [BW-1:0] BCNT_MAX = BW'(CPB - 1);
    localparam logic [2:0]    IDX_LAST = 3'(UART_DATA_BITS - 1);

    tx_state_t         state_q, state_d;
    logic [BW-1:0]     bcnt_q, bcnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [7:0]        shreg_q, shreg_d;
    logic              tx_q, tx_d;
    logic              overflow_q;

    logic              pop;
    logic [7:0]        fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic              bit_done;
    logic              unused_dat;

    assign unused_dat = ^bus.mmio_dat[31:8];

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .Rst   (Rst),
        .push  (bus.mmio_wea),
        .pop   (pop),
        .din   (bus.mmio_dat[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (bus.fifo_count)
    );

    assign bus.fifo_full = fifo_full;
    assign bus.overflow  = overflow_q;
    assign bit_done      = (bcnt_q == '0);

    // State register.
    always_ff @(posedge clk) begin
        if (Rst) begin
            state_q    <= IDLE;
            bcnt_q     <= '0;
            idx_q      <= '0;
            shreg_q    <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bcnt_q     <= bcnt_d;
            idx_q      <= idx_d;
            shreg_q    <= shreg_d;
            tx_q       <= tx_d;
            overflow_q <= bus.mmio_wea & fifo_full;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_d = fifo_dout;
                    bcnt_d  = BCNT_MAX;
                    state_d = START;
                end
            end
            START: begin
                if (bit_done) begin
                    idx_d   = '0;
                    bcnt_d  = BCNT_MAX;
                    state_d = DATA;
                end else begin
                    bcnt_d = bcnt_q - BW'(1);
                end
            end
            DATA: begin
                if (bit_done) begin
                    bcnt_d = BCNT_MAX;
                    if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    bcnt_d = bcnt_q - BW'(1);
                end
            end
            PARITY: begin
                if (bit_done) begin
                    bcnt_d  = BCNT_MAX;
                    state_d = STOP;
                end else begin
                    bcnt_d = bcnt_q - BW'(1);
                end
            end
            STOP: begin
                if (bit_done) begin
                    // Chain straight into the next start bit when more data is queued.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shreg_d = fifo_dout;
                        bcnt_d  = BCNT_MAX;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    bcnt_d = bcnt_q - BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: tx is computed from the next state so the line changes on
    // the same edge as the state and comes straight out of a flop.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[idx_d];
            PARITY:  tx_d = ^shreg_d;
            default: tx_d = 1'b1;
        endcase
    end

    assign tx   = tx_q;
    assign busy = (state_q != IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_uart_tx_mmio.sv
module tb_uart_tx_mmio;
    localparam int unsigned CPB = 10;
    localparam int unsigned DEP = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic clk = 1'b0;
    logic Rst = 1'b1;
    logic tx;
    logic busy;

    int errors = 0;
    int checks = 0;

    uart_tx_mmio_if #(.FIFO_DEPTH(DEP)) bus ();

    uart_tx_mmio #(
        .CLK_FREQ_HZ (100_000_000),
        .BAUD        (10_000_000),
        .FIFO_DEPTH  (DEP)
    ) dut (
        .clk  (clk),
        .Rst  (Rst),
        .bus  (bus),
        .tx   (tx),
        .busy (busy)
    );

    always #5 clk = ~clk;

    // Serial monitor: decodes frames from tx, sampling mid-bit on the negedge.
    logic [7:0] rx_q[$];
    int         start_q[$];
    int         frame_bad = 0;
    int         cyc = 0;
    bit         mon_active = 0;
    bit         mon_prev = 1;
    int         mon_cnt = 0;
    logic [7:0] mon_byte;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (Rst) begin
                mon_active = 0;
                mon_prev   = 1;
            end else begin
                if (!mon_active) begin
                    if (mon_prev && !tx) begin
                        mon_active = 1;
                        mon_cnt    = 0;
                        start_q.push_back(cyc);
                    end
                end else begin
                    mon_cnt++;
                end
                if (mon_active && (mon_cnt % CPB) == CPB / 2) begin
                    automatic int k = mon_cnt / CPB;
                    if (k == 0) begin
                        if (tx !== 1'b0) frame_bad++;
                    end else if (k <= 8) begin
                        mon_byte[k-1] = tx;
                    end else if (k == NB - 1) begin
                        if (tx !== 1'b1) frame_bad++;
                        rx_q.push_back(mon_byte);
                        mon_active = 0;
                    end else begin
                        if (tx !== ^mon_byte) frame_bad++;
                    end
                end
                mon_prev = tx;
            end
        end
    end

    function automatic logic [10:0] exp_frame(input logic [7:0] b);
        logic [10:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = b;
`ifdef UART_TX_PARITY_EN
        f[9]   = ^b;
`endif
        return f;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        bus.mmio_wea = 1'b0;
        bus.mmio_dat = '0;
        step();
        step();
        Rst = 1'b0;
        rx_q.delete();
        start_q.delete();
        frame_bad = 0;
    endtask

    task automatic wait_drain(input int limit, output int peak);
        int n;
        n = 0;
        peak = 0;
        while ((busy || mon_active) && n < limit) begin
            step();
            if (int'(bus.fifo_count) > peak) peak = int'(bus.fifo_count);
            n++;
        end
        checks++;
        if (busy || mon_active) begin
            errors++;
            $display("FAIL drain_timeout: busy=%0b after %0d cycles, required 0", busy, limit);
        end
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        bus.mmio_wea = 1'b1;
        bus.mmio_dat = 32'h0000_00AA;
        step();
        step();
        step();
        bus.mmio_wea = 1'b0;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.fifo_count); end
        checks++; if (bus.fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", bus.fifo_full); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", bus.overflow); end
        Rst = 1'b0;
    endtask

    task automatic test_frame(input logic [7:0] b);
        logic [10:0] f;
        f = exp_frame(b);
        do_reset();
        bus.mmio_dat = {24'hDEAD_BE, b};
        bus.mmio_wea = 1'b1;
        step();
        bus.mmio_wea = 1'b0;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL frame_pre_tx: got %b want 1", tx); end
        checks++; if (bus.fifo_count !== 3'd1) begin errors++; $display("FAIL frame_count_push: got %0d want 1", bus.fifo_count); end
        for (int i = 0; i < NB * CPB; i++) begin
            step();
            checks++;
            if (tx !== f[i / CPB]) begin
                errors++;
                $display("FAIL frame_bit%0d_cyc%0d: byte %h tx=%b want %b", i / CPB, i, b, tx, f[i / CPB]);
            end
            if (i == 0) begin
                checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL frame_count_pop: got %0d want 0", bus.fifo_count); end
            end
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL frame_busy_last_stop: got %b want 1", busy); end
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL frame_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        int peak;
        do_reset();
        bus.mmio_wea = 1'b1;
        bus.mmio_dat = 32'h0000_00A5;
        step();
        peak = int'(bus.fifo_count);
        bus.mmio_dat = 32'h0000_003C;
        step();
        bus.mmio_wea = 1'b0;
        if (int'(bus.fifo_count) > peak) peak = int'(bus.fifo_count);
        begin
            int p2;
            wait_drain(1000, p2);
            if (p2 > peak) peak = p2;
        end
        checks++; if (rx_q.size() != 2) begin errors++; $display("FAIL b2b_nframes: got %0d want 2", rx_q.size()); end
        else begin
            checks++; if (rx_q[0] !== 8'hA5) begin errors++; $display("FAIL b2b_byte0: got %h want a5", rx_q[0]); end
            checks++; if (rx_q[1] !== 8'h3C) begin errors++; $display("FAIL b2b_byte1: got %h want 3c", rx_q[1]); end
            checks++; if (start_q[1] - start_q[0] != NB * CPB) begin errors++; $display("FAIL b2b_gap: got %0d want %0d", start_q[1] - start_q[0], NB * CPB); end
        end
        checks++; if (peak != 1) begin errors++; $display("FAIL b2b_peak_count: got %0d want 1", peak); end
        checks++; if (frame_bad != 0) begin errors++; $display("FAIL b2b_framing: got %0d bad bits want 0", frame_bad); end
    endtask

    task automatic test_overflow();
        int peak;
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            bus.mmio_wea = 1'b1;
            bus.mmio_dat = 32'(i);
            step();
            if (i == 5) begin
                checks++; if (bus.fifo_count !== 3'd4) begin errors++; $display("FAIL ovf_count4: got %0d want 4", bus.fifo_count); end
                checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b want 0", bus.overflow); end
            end
        end
        bus.mmio_wea = 1'b0;
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse: got %b want 1", bus.overflow); end
        checks++; if (bus.fifo_full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b want 1", bus.fifo_full); end
        step();
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_pulse_end: got %b want 0", bus.overflow); end
        wait_drain(2000, peak);
        checks++; if (rx_q.size() != 5) begin errors++; $display("FAIL ovf_nframes: got %0d want 5", rx_q.size()); end
        else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (rx_q[i] !== 8'(i + 1)) begin errors++; $display("FAIL ovf_byte%0d: got %h want %h", i, rx_q[i], 8'(i + 1)); end
            end
        end
        checks++; if (frame_bad != 0) begin errors++; $display("FAIL ovf_framing: got %0d bad bits want 0", frame_bad); end
    endtask

    task automatic test_full_pop();
        int peak;
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            bus.mmio_wea = 1'b1;
            bus.mmio_dat = 32'(8'h10 + i);
            step();
        end
        bus.mmio_wea = 1'b0;
        for (int i = 0; i < NB * CPB - 4; i++) step();
        checks++; if (bus.fifo_count !== 3'd4) begin errors++; $display("FAIL fullpop_count_before: got %0d want 4", bus.fifo_count); end
        bus.mmio_wea = 1'b1;
        bus.mmio_dat = 32'h0000_0077;
        step();
        bus.mmio_wea = 1'b0;
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL fullpop_overflow: got %b want 1", bus.overflow); end
        checks++; if (bus.fifo_count !== 3'd3) begin errors++; $display("FAIL fullpop_count_after: got %0d want 3", bus.fifo_count); end
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL fullpop_next_start: got %b want 0", tx); end
        wait_drain(2000, peak);
        checks++; if (rx_q.size() != 5) begin errors++; $display("FAIL fullpop_nframes: got %0d want 5", rx_q.size()); end
        else begin
            checks++; if (rx_q[4] !== 8'h15) begin errors++; $display("FAIL fullpop_last: got %h want 15", rx_q[4]); end
        end
    endtask

    task automatic test_reset_mid();
        int zeros;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            bus.mmio_wea = 1'b1;
            bus.mmio_dat = (i == 0) ? 32'h0000_00FF : 32'(8'hB0 + i);
            step();
        end
        bus.mmio_wea = 1'b0;
        checks++; if (bus.fifo_count !== 3'd2) begin errors++; $display("FAIL rstmid_queued: got %0d want 2", bus.fifo_count); end
        for (int i = 0; i < 33; i++) step();
        Rst = 1'b1;
        step();
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rstmid_tx: got %b want 1", tx); end
        checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL rstmid_count: got %0d want 0", bus.fifo_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        Rst = 1'b0;
        zeros = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (tx !== 1'b1 || busy !== 1'b0) zeros++;
        end
        checks++; if (zeros != 0) begin errors++; $display("FAIL rstmid_quiet: got %0d active cycles want 0", zeros); end
        checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL rstmid_frames: got %0d want 0", rx_q.size()); end
    endtask

    initial begin
        bus.mmio_wea = 1'b0;
        bus.mmio_dat = '0;
        test_reset();
        test_frame(8'h55);
        test_frame(8'h07);
        test_back_to_back();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
